// File: rtl/common_sync_fifo_gearbox.sv
// rtl/common_sync_fifo_gearbox.sv - synchronous FIFO storage with push/pop width conversion
//
// Purpose: storage end of a common_sync_fifo. Each push stores DWI words of DW bits.
// Each pop removes DWO words. Occupancy and free space are reported in DW-word units.
// rdata is show-ahead: it always presents the DWO oldest stored words.
//
// Ports:
//   clk      in   1       rising-edge clock
//   rst_n    in   1       asynchronous active-low reset
//   wdata    in   DW*DWI  push data, word k = wdata[k*DW +: DW], word 0 oldest
//   write    in   1       push request, taken when nfull=1
//   read     in   1       pop request, taken when nempty=1
//   clr      in   1       synchronous flush, overrides write/read
//   rdata    out  DW*DWO  show-ahead data, word k = entry rptr+k
//   nfull    out  1       free >= DWI
//   nempty   out  1       occ >= DWO
//   free     out  DL+1    free words
//   occ      out  DL+1    stored words
//   ovf_o    out  1       sticky dropped-push flag (COMMON_SYNC_FIFO_ERR_CHK_EN only)
//   udf_o    out  1       sticky dropped-pop flag  (COMMON_SYNC_FIFO_ERR_CHK_EN only)
//
// Optional feature macro: COMMON_SYNC_FIFO_ERR_CHK_EN

module common_sync_fifo_gearbox #(
    parameter int DW  = 32,
    parameter int DWI = 1,
    parameter int DWO = 1,
    parameter int DL  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DW*DWI-1:0] wdata,
    input  logic              write,
    input  logic              read,
    input  logic              clr,
    output logic [DW*DWO-1:0] rdata,
    output logic              nfull,
    output logic              nempty,
    output logic [DL:0]       free,
`ifdef COMMON_SYNC_FIFO_ERR_CHK_EN
    output logic [DL:0]       occ,
    output logic              ovf_o,
    output logic              udf_o
`else
    output logic [DL:0]       occ
`endif
);

    localparam int          DEPTH   = 2 ** DL;
    localparam logic [DL:0] DEPTH_W = (DL+1)'(DEPTH);
    localparam logic [DL:0] DWI_W   = (DL+1)'(DWI);
    localparam logic [DL:0] DWO_W   = (DL+1)'(DWO);

    generate
        if (DWI < 1 || DWI > DEPTH) begin : g_bad_dwi
            $error("common_sync_fifo_gearbox: DWI must be in 1..2**DL");
        end
        if (DWO < 1 || DWO > DEPTH) begin : g_bad_dwo
            $error("common_sync_fifo_gearbox: DWO must be in 1..2**DL");
        end
    endgenerate

    logic [DW-1:0] mem [0:DEPTH-1];
    logic [DL-1:0] wptr;
    logic [DL-1:0] rptr;
    logic [DL:0]   occ_next;
    logic          push;
    logic          pop;

    // Flags come only from the registered occupancy, so a pop never frees room
    // for a push in the same cycle and no request input reaches an output.
    assign free   = DEPTH_W - occ;
    assign nfull  = (free >= DWI_W);
    assign nempty = (occ >= DWO_W);

    assign push = write && nfull;
    assign pop  = read && nempty;

    always_comb begin
        occ_next = occ;
        if (push) begin
            occ_next = occ_next + DWI_W;
        end
        if (pop) begin
            occ_next = occ_next - DWO_W;
        end
    end

    // Pointer increments truncate to DL bits so they wrap modulo DEPTH, which
    // also covers DWI or DWO equal to DEPTH (pointer stays put).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            occ  <= '0;
        end else if (clr) begin
            wptr <= '0;
            rptr <= '0;
            occ  <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + DWI_W[DL-1:0];
            end
            if (pop) begin
                rptr <= rptr + DWO_W[DL-1:0];
            end
            occ <= occ_next;
        end
    end

    // Storage has no reset; stale entries are unreachable because occ gates reads.
    always_ff @(posedge clk) begin
        if (push && !clr) begin
            for (int k = 0; k < DWI; k++) begin
                mem[wptr + DL'(k)] <= wdata[k*DW +: DW];
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < DWO; g++) begin : g_rd
            assign rdata[g*DW +: DW] = mem[rptr + DL'(g)];
        end
    endgenerate

`ifdef COMMON_SYNC_FIFO_ERR_CHK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_o <= 1'b0;
            udf_o <= 1'b0;
        end else if (clr) begin
            ovf_o <= 1'b0;
            udf_o <= 1'b0;
        end else begin
            if (write && !nfull) begin
                ovf_o <= 1'b1;
            end
            if (read && !nempty) begin
                udf_o <= 1'b1;
            end
        end
    end

    a_occ_range: assert property (@(posedge clk) disable iff (!rst_n) occ <= DEPTH_W);
    a_occ_free:  assert property (@(posedge clk) disable iff (!rst_n)
                                  ({1'b0, occ} + {1'b0, free}) == {1'b0, DEPTH_W});
`endif

endmodule

// File: tb/tb_common_sync_fifo_gearbox.sv
// tb/tb_common_sync_fifo_gearbox.sv - directed self-checking bench for common_sync_fifo_gearbox

module tb_common_sync_fifo_gearbox;

    localparam int DW  = 8;
    localparam int DWI = 2;
    localparam int DWO = 1;
    localparam int DL  = 2;

    logic          clk;
    logic          rst_n;
    logic [15:0]   wdata;
    logic          write;
    logic          read;
    logic          clr;
    logic [7:0]    rdata;
    logic          nfull;
    logic          nempty;
    logic [DL:0]   free;
    logic [DL:0]   occ;
`ifdef COMMON_SYNC_FIFO_ERR_CHK_EN
    logic          ovf_o;
    logic          udf_o;
`endif

    int n_checks = 0;
    int n_errors = 0;

    common_sync_fifo_gearbox #(.DW(DW), .DWI(DWI), .DWO(DWO), .DL(DL)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .wdata  (wdata),
        .write  (write),
        .read   (read),
        .clr    (clr),
        .rdata  (rdata),
        .nfull  (nfull),
        .nempty (nempty),
        .free   (free),
`ifdef COMMON_SYNC_FIFO_ERR_CHK_EN
        .occ    (occ),
        .ovf_o  (ovf_o),
        .udf_o  (udf_o)
`else
        .occ    (occ)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One clock with the given requests, sampled 1 ns after the edge.
    task automatic cyc(input logic w, input logic r, input logic c, input logic [15:0] d);
        write = w;
        read  = r;
        clr   = c;
        wdata = d;
        @(posedge clk);
        #1;
        write = 1'b0;
        read  = 1'b0;
        clr   = 1'b0;
        check("inv_occ_free", 32'(occ) + 32'(free), 32'd4);
    endtask

    logic [7:0] q[$];
    logic [7:0] lo;
    logic [7:0] exp_b;

    initial begin
        rst_n = 1'b0;
        write = 1'b0;
        read  = 1'b0;
        clr   = 1'b0;
        wdata = '0;

        // 1. reset
        repeat (3) @(posedge clk);
        #1;
        check("rst_occ", 32'(occ), 0);
        check("rst_free", 32'(free), 4);
        check("rst_nfull", 32'(nfull), 1);
        check("rst_nempty", 32'(nempty), 0);
`ifdef COMMON_SYNC_FIFO_ERR_CHK_EN
        check("rst_ovf", 32'(ovf_o), 0);
        check("rst_udf", 32'(udf_o), 0);
`endif
        rst_n = 1'b1;

        // 2. single push then pop
        cyc(1, 0, 0, 16'hBBAA);
        check("t2_occ", 32'(occ), 2);
        check("t2_nempty", 32'(nempty), 1);
        check("t2_rdata", 32'(rdata), 32'hAA);
        cyc(0, 1, 0, 16'h0);
        check("t2_pop_rdata", 32'(rdata), 32'hBB);
        check("t2_pop_occ", 32'(occ), 1);
        cyc(0, 1, 0, 16'h0);
        check("t2_empty_occ", 32'(occ), 0);
        check("t2_empty_nempty", 32'(nempty), 0);

        // 3. fill, overflow, drain, underflow
        cyc(1, 0, 0, 16'h2211);
        cyc(1, 0, 0, 16'h4433);
        check("t3_full_occ", 32'(occ), 4);
        check("t3_full_free", 32'(free), 0);
        check("t3_full_nfull", 32'(nfull), 0);
        cyc(1, 0, 0, 16'h6655);
        check("t3_ovf_occ", 32'(occ), 4);
`ifdef COMMON_SYNC_FIFO_ERR_CHK_EN
        check("t3_ovf_flag", 32'(ovf_o), 1);
`endif
        check("t3_rd0", 32'(rdata), 32'h11);
        cyc(0, 1, 0, 16'h0);
        check("t3_rd1", 32'(rdata), 32'h22);
        cyc(0, 1, 0, 16'h0);
        check("t3_rd2", 32'(rdata), 32'h33);
        cyc(0, 1, 0, 16'h0);
        check("t3_rd3", 32'(rdata), 32'h44);
        cyc(0, 1, 0, 16'h0);
        check("t3_drained_occ", 32'(occ), 0);
        cyc(0, 1, 0, 16'h0);
        check("t3_udf_occ", 32'(occ), 0);
        check("t3_udf_nempty", 32'(nempty), 0);
`ifdef COMMON_SYNC_FIFO_ERR_CHK_EN
        check("t3_udf_flag", 32'(udf_o), 1);
`endif
        cyc(0, 0, 1, 16'h0);

        // 4. simultaneous push and pop
        cyc(1, 0, 0, 16'hA1A0);
        cyc(0, 1, 0, 16'h0);
        check("t4_occ1", 32'(occ), 1);
        check("t4_head_a1", 32'(rdata), 32'hA1);
        cyc(1, 1, 0, 16'hB1B0);
        check("t4_pp_occ", 32'(occ), 2);
        check("t4_pp_head", 32'(rdata), 32'hB0);
        cyc(1, 0, 0, 16'hC1C0);
        cyc(0, 1, 0, 16'h0);
        check("t4_occ3", 32'(occ), 3);
        check("t4_occ3_nfull", 32'(nfull), 0);
        check("t4_head_b1", 32'(rdata), 32'hB1);
        cyc(1, 1, 0, 16'hD1D0);
        check("t4_pop_only_occ", 32'(occ), 2);
        check("t4_pop_only_head", 32'(rdata), 32'hC0);
        cyc(0, 1, 0, 16'h0);
        check("t4_tail_c1", 32'(rdata), 32'hC1);
        cyc(0, 1, 0, 16'h0);
        check("t4_drained", 32'(occ), 0);

        // 5. wrap: ten pushes interleaved with pops against a queue model
        for (int i = 0; i < 10; i++) begin
            lo = 8'h40 + 8'(2 * i);
            cyc(1, 0, 0, {lo + 8'd1, lo});
            q.push_back(lo);
            q.push_back(lo + 8'd1);
            for (int j = 0; j < 2; j++) begin
                exp_b = q.pop_front();
                check("t5_seq", 32'(rdata), 32'(exp_b));
                cyc(0, 1, 0, 16'h0);
            end
        end
        check("t5_end_occ", 32'(occ), 0);

        // 6. clr overriding write/read at occ=3
        cyc(0, 1, 0, 16'h0);
        cyc(1, 0, 0, 16'h5150);
        cyc(1, 0, 0, 16'h5352);
        cyc(1, 0, 0, 16'h5554);
        cyc(0, 1, 0, 16'h0);
        check("t6_occ3", 32'(occ), 3);
`ifdef COMMON_SYNC_FIFO_ERR_CHK_EN
        check("t6_pre_ovf", 32'(ovf_o), 1);
        check("t6_pre_udf", 32'(udf_o), 1);
`endif
        cyc(1, 1, 1, 16'h5756);
        check("t6_clr_occ", 32'(occ), 0);
        check("t6_clr_free", 32'(free), 4);
        check("t6_clr_nempty", 32'(nempty), 0);
`ifdef COMMON_SYNC_FIFO_ERR_CHK_EN
        check("t6_clr_ovf", 32'(ovf_o), 0);
        check("t6_clr_udf", 32'(udf_o), 0);
`endif

        // asynchronous reset in the middle of a burst
        cyc(1, 0, 0, 16'h6160);
        write = 1'b1;
        wdata = 16'h6362;
        @(posedge clk);
        #2;
        check("t6_burst_occ", 32'(occ), 4);
        rst_n = 1'b0;
        #1;
        check("t6_arst_occ", 32'(occ), 0);
        check("t6_arst_free", 32'(free), 4);
        check("t6_arst_nfull", 32'(nfull), 1);
        check("t6_arst_nempty", 32'(nempty), 0);
        write = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(0, 0, 0, 16'h0);
        check("t6_post_occ", 32'(occ), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
